// File: rtl/ac_iq_probe.sv
// I/Q probe: correlates a sample stream against reference cos/sin over 2^LOG2N beats
// and presents the window average on a valid/ready output.
module ac_iq_probe #(
    parameter int unsigned DW    = 16,
    parameter int unsigned LOG2N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [DW-1:0] s_data,
    input  logic signed [DW-1:0] ref_cos,
    input  logic signed [DW-1:0] ref_sin,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic signed [2*DW-1:0] m_i,
    output logic signed [2*DW-1:0] m_q,
    output logic                 busy
);

    localparam int unsigned PW = 2 * DW;
    localparam int unsigned AW = 2 * DW + LOG2N;
    localparam logic [LOG2N-1:0] CntLast = '1;

    typedef enum logic [1:0] {StIdle, StAcc, StOut} state_t;

    state_t                 state_q, state_d;
    logic signed [AW-1:0]   acc_i_q, acc_i_d;
    logic signed [AW-1:0]   acc_q_q, acc_q_d;
    logic [LOG2N-1:0]       cnt_q, cnt_d;
    logic signed [PW-1:0]   m_i_q, m_i_d;
    logic signed [PW-1:0]   m_q_q, m_q_d;

    logic signed [PW-1:0]   prod_i, prod_q;
    logic signed [AW-1:0]   sum_i, sum_q;
    logic signed [AW-1:0]   shr_i, shr_q;
    logic                   beat;

    // Operands are sign-extended to PW before multiplying, so -2^(DW-1) squared fits.
    assign prod_i = s_data * ref_cos;
    assign prod_q = s_data * ref_sin;

    assign sum_i = acc_i_q + {{LOG2N{prod_i[PW-1]}}, prod_i};
    assign sum_q = acc_q_q + {{LOG2N{prod_q[PW-1]}}, prod_q};

    assign shr_i = sum_i >>> LOG2N;
    assign shr_q = sum_q >>> LOG2N;

    assign s_ready = (state_q == StAcc);
    assign m_valid = (state_q == StOut);
    assign busy    = (state_q != StIdle);
    assign beat    = s_valid & s_ready;
    assign m_i     = m_i_q;
    assign m_q     = m_q_q;

    always_comb begin
        state_d = state_q;
        acc_i_d = acc_i_q;
        acc_q_d = acc_q_q;
        cnt_d   = cnt_q;
        m_i_d   = m_i_q;
        m_q_d   = m_q_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    acc_i_d = '0;
                    acc_q_d = '0;
                    cnt_d   = '0;
                    state_d = StAcc;
                end
            end
            StAcc: begin
                if (beat) begin
                    acc_i_d = sum_i;
                    acc_q_d = sum_q;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        state_d = StOut;
                        m_i_d   = shr_i[PW-1:0];
                        m_q_d   = shr_q[PW-1:0];
                    end
                end
            end
            StOut: begin
                if (m_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_i_q <= '0;
            acc_q_q <= '0;
            cnt_q   <= '0;
            m_i_q   <= '0;
            m_q_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_i_q <= acc_i_d;
            acc_q_q <= acc_q_d;
            cnt_q   <= cnt_d;
            m_i_q   <= m_i_d;
            m_q_q   <= m_q_d;
        end
    end

endmodule

// File: tb/tb_ac_iq_probe.sv
// Bench for ac_iq_probe at DW=16, LOG2N=2: vector table, random windows and
// hand-written reset/backpressure sequences, checked through a result scoreboard.
module tb_ac_iq_probe;

    localparam int unsigned DW    = 16;
    localparam int unsigned LOG2N = 2;
    localparam int          NB    = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic                   s_valid;
    logic                   s_ready;
    logic signed [DW-1:0]   s_data;
    logic signed [DW-1:0]   ref_cos;
    logic signed [DW-1:0]   ref_sin;
    logic                   m_valid;
    logic                   m_ready;
    logic signed [2*DW-1:0] m_i;
    logic signed [2*DW-1:0] m_q;
    logic                   busy;

    ac_iq_probe #(
        .DW    (DW),
        .LOG2N (LOG2N)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .ref_cos (ref_cos),
        .ref_sin (ref_sin),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_i     (m_i),
        .m_q     (m_q),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NB-1:0][DW-1:0] d;
        logic [NB-1:0][DW-1:0] c;
        logic [NB-1:0][DW-1:0] s;
        int                    gap_mode;  // 0: none, 1: k idle cycles before beat k, 2: random
        longint                exp_i;
        longint                exp_q;
        string                 name;
    } vec_t;

    typedef struct {
        longint i;
        longint q;
        string  name;
    } res_t;

    res_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        ref_cos = '0;
        ref_sin = '0;
    endtask

    // Runs one window from IDLE; pushes the expected result. Called on a negedge.
    task automatic run_window(input vec_t v);
        res_t r;
        int   g;
        start   = 1'b1;
        s_valid = 1'b1;  // offered in IDLE, must not be consumed
        s_data  = 16'($urandom);
        ref_cos = 16'($urandom);
        ref_sin = 16'($urandom);
        @(negedge clk);
        idle_inputs();
        check({v.name, "_busy_acc"}, longint'(busy), 1);
        for (int k = 0; k < NB; k++) begin
            g = (v.gap_mode == 1) ? k : (v.gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
            repeat (g) @(negedge clk);
            check({v.name, "_s_ready"}, longint'(s_ready), 1);
            if (k == NB - 1) check({v.name, "_m_valid_early"}, longint'(m_valid), 0);
            s_valid = 1'b1;
            s_data  = v.d[k];
            ref_cos = v.c[k];
            ref_sin = v.s[k];
            @(negedge clk);
            s_valid = 1'b0;
        end
        r.i    = v.exp_i;
        r.q    = v.exp_q;
        r.name = v.name;
        sb.push_back(r);
        check({v.name, "_latency"}, longint'(m_valid), 1);
    endtask

    task automatic drain();
        res_t r;
        int   n = 0;
        while (!m_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        r = sb.pop_front();
        check({r.name, "_timeout"}, longint'(m_valid), 1);
        check({r.name, "_m_i"}, longint'(m_i), r.i);
        check({r.name, "_m_q"}, longint'(m_q), r.q);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check({r.name, "_idle_m_valid"}, longint'(m_valid), 0);
        check({r.name, "_idle_busy"}, longint'(busy), 0);
        check({r.name, "_m_i_kept"}, longint'(m_i), r.i);
    endtask

    function automatic vec_t model_vec(input string name);
        vec_t   v;
        longint si = 0;
        longint sq = 0;
        for (int k = 0; k < NB; k++) begin
            v.d[k] = 16'($urandom);
            v.c[k] = 16'($urandom);
            v.s[k] = 16'($urandom);
            si += longint'($signed(v.d[k])) * longint'($signed(v.c[k]));
            sq += longint'($signed(v.d[k])) * longint'($signed(v.s[k]));
        end
        v.gap_mode = 2;
        v.exp_i    = si >>> LOG2N;
        v.exp_q    = sq >>> LOG2N;
        v.name     = name;
        return v;
    endfunction

    vec_t vecs[5];
    vec_t v;

    initial begin
        vecs[0].d = {4{16'd1000}};
        vecs[0].c = {4{16'd16384}};
        vecs[0].s = {4{16'd0}};
        vecs[0].gap_mode = 0;
        vecs[0].exp_i = 16384000;
        vecs[0].exp_q = 0;
        vecs[0].name = "basic";

        vecs[1].d = {4{16'h8000}};
        vecs[1].c = {4{16'h8000}};
        vecs[1].s = {4{16'h7FFF}};
        vecs[1].gap_mode = 0;
        vecs[1].exp_i = 1073741824;
        vecs[1].exp_q = -1073709056;
        vecs[1].name = "extremes";

        // beat 0: I product -1, Q product 3; remaining beats zero
        vecs[2].d = {16'd0, 16'd0, 16'd0, 16'hFFFF};
        vecs[2].c = {16'd7, 16'd7, 16'd7, 16'd1};
        vecs[2].s = {16'd9, 16'd9, 16'd9, 16'hFFFD};
        vecs[2].gap_mode = 0;
        vecs[2].exp_i = -1;
        vecs[2].exp_q = 0;
        vecs[2].name = "floor";

        vecs[3].d = {16'd4, 16'd3, 16'd2, 16'd1};
        vecs[3].c = {16'd8, 16'd7, 16'd6, 16'd5};
        vecs[3].s = {4{16'hFFFF}};
        vecs[3].gap_mode = 1;
        vecs[3].exp_i = 17;
        vecs[3].exp_q = -3;
        vecs[3].name = "mixed_gaps";

        vecs[4] = vecs[0];
        vecs[4].gap_mode = 1;
        vecs[4].name = "basic_gaps";

        // Reset with random inputs, including start and s_valid
        rst     = 1'b1;
        m_ready = 1'b0;
        idle_inputs();
        for (int c = 0; c < 2; c++) begin
            start   = 1'($urandom);
            s_valid = 1'b1;
            m_ready = 1'($urandom);
            s_data  = 16'($urandom);
            ref_cos = 16'($urandom);
            ref_sin = 16'($urandom);
            @(negedge clk);
            check("rst_s_ready", longint'(s_ready), 0);
            check("rst_m_valid", longint'(m_valid), 0);
            check("rst_busy", longint'(busy), 0);
            check("rst_m_i", longint'(m_i), 0);
            check("rst_m_q", longint'(m_q), 0);
        end
        rst     = 1'b0;
        m_ready = 1'b0;
        idle_inputs();
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        check("idle_no_start_busy", longint'(busy), 0);
        check("idle_no_start_s_ready", longint'(s_ready), 0);

        for (int n = 0; n < 5; n++) begin
            run_window(vecs[n]);
            drain();
        end

        for (int n = 0; n < 3; n++) begin
            v = model_vec($sformatf("rand%0d", n));
            run_window(v);
            drain();
        end

        // Backpressure: hold result 5 cycles while start pulses
        run_window(vecs[1]);
        for (int c = 0; c < 5; c++) begin
            start = c[0];
            @(negedge clk);
            check("bp_m_valid", longint'(m_valid), 1);
            check("bp_s_ready", longint'(s_ready), 0);
            check("bp_busy", longint'(busy), 1);
            check("bp_m_i", longint'(m_i), sb[0].i);
            check("bp_m_q", longint'(m_q), sb[0].q);
        end
        start = 1'b0;
        drain();

        // Reset mid-window discards the partial accumulation
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            s_valid = 1'b1;
            s_data  = 16'd100;
            ref_cos = 16'd100;
            ref_sin = 16'd0;
            @(negedge clk);
        end
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", longint'(busy), 0);
        check("midrst_s_ready", longint'(s_ready), 0);
        check("midrst_m_i", longint'(m_i), 0);
        check("midrst_m_q", longint'(m_q), 0);
        v.d = {4{16'd1}};
        v.c = {4{16'd1}};
        v.s = {4{16'd1}};
        v.gap_mode = 0;
        v.exp_i = 1;
        v.exp_q = 1;
        v.name = "after_rst";
        run_window(v);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
